multi_cycle_mips: RTL and testbench
===================================

MULTI_CYCLE_MIPS -- requirements
Module: multi_cycle_mips

Interface
REQ-001 SHALL have parameter IMEM_AW, default 8, instruction memory address width in words (depth 2**IMEM_AW).
REQ-002 SHALL have parameter DMEM_AW, default 8, data memory address width in words (depth 2**DMEM_AW).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port WE  input  1  instruction memory write enable.
REQ-006 SHALL have port W_Addr  input  IMEM_AW  instruction memory word write address.
REQ-007 SHALL have port W_Ins  input  32  instruction word to write.
REQ-008 SHALL have port RUN  input  1  level; 1 = execute, 0 = stop at next instruction boundary.
REQ-009 SHALL have port SLCT  input  5  debug view select for Result.
REQ-010 SHALL have port PC  output  32  current program counter.
REQ-011 SHALL have port Result  output  32  debug view selected by SLCT.
REQ-012 SHALL have port STATE  output  3  FSM state encoding.
REQ-013 SHALL have port HALTED  output  1  high while in HALT.

Function
REQ-014 FSM states and encodings SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-015 IDLE->FETCH when RUN=1; otherwise stays IDLE.
REQ-016 FETCH SHALL latch IR from imem[PC[IMEM_AW+1:2]] and set PC=PC+4; DECODE SHALL latch A=rs, B=rt, sign-extended imm.
REQ-017 Supported ops: R-type add/sub/and/or/slt (funct 0x20/0x22/0x24/0x25/0x2A), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02, halt 0x3F.
REQ-018 Latency: R-type/addi 4 cycles (F,D,E,WB); lw 5 (F,D,E,M,WB); sw 4 (F,D,E,M); beq/j/unknown 3 (F,D,E).
REQ-019 Arithmetic SHALL be 32-bit modulo 2**32, no overflow trap; slt signed compare yielding 0 or 1.
REQ-020 beq taken target SHALL be PC+(sext(imm)<<2), PC already incremented; j target SHALL be {PC[31:28], IR[25:0], 2'b00}.
REQ-021 Data address SHALL be ALUOut[DMEM_AW+1:2]; upper bits ignored (aliasing); low two bits ignored.
REQ-022 Writes to register 0 SHALL be discarded; register 0 reads SHALL be 0.
REQ-023 Unknown opcode/funct SHALL execute as NOP, no register or memory write.
REQ-024 halt SHALL enter HALT after DECODE; HALT persists until RST regardless of RUN.
REQ-025 At last state of each instruction SHALL go FETCH if RUN=1 else IDLE; RUN deasserted mid-instruction SHALL not abort it.
REQ-026 PC SHALL wrap: fetch index wraps modulo 2**IMEM_AW.
REQ-027 WE SHALL write imem[W_Addr]=W_Ins only in IDLE or HALT; ignored in all other states.
REQ-028 Cycle counter SHALL increment each cycle not in IDLE/HALT; retire counter SHALL increment once per completed instruction including halt; both wrap at 2**32.
REQ-029 Result mux: 0 PC, 1 IR, 2 A, 3 B, 4 ALUOut, 5 MDR, 6 last writeback data, 7 cycle count, 8 retire count, 16-31 register (SLCT-16), others 0; combinational from registered state.

Reset
REQ-030 RST SHALL force STATE=IDLE, PC=0, IR/A/B/ALUOut/MDR=0, all 32 registers=0, both counters=0, HALTED=0, overriding any simultaneous WE or RUN.
REQ-031 RST SHALL NOT alter instruction or data memory contents; reset mid-instruction abandons it with no further writes.

Verification
REQ-032 Load addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; halt; RUN=1 -> SLCT=19 reads 12, HALTED=1 after 15 cycles, retire count 4, cycle count 15.
REQ-033 sw $3,8($0) then lw $4,8($0) -> SLCT=20 reads stored value; lw takes 5 cycles, sw 4.
REQ-034 beq $0,$0,-1 with RUN dropped after 10 cycles -> completes current branch, STATE=IDLE, PC unchanged loop address.
REQ-035 addi $0,$0,9 then slt $5,$6,$7 with $6=-1,$7=1 -> SLCT=16 reads 0, SLCT=21 reads 1.
REQ-036 WE pulse during EXEC -> imem unchanged; RST during MEM of sw -> data word unchanged, STATE=0, PC=0 next cycle.

Source files
------------

// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS subset core with on-chip instruction and data memories.
// One instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB]; the
// instruction memory is loaded through WE/W_Addr/W_Ins while the core is
// parked in IDLE or HALT. Result exposes internal state for debug.
module multi_cycle_mips #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WE,
  input  logic [IMEM_AW-1:0] W_Addr,
  input  logic [31:0]        W_Ins,
  input  logic               RUN,
  input  logic [4:0]         SLCT,
  output logic [31:0]        PC,
  output logic [31:0]        Result,
  output logic [2:0]         STATE,
  output logic               HALTED
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Architectural and micro-architectural state
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_imm;
  logic [31:0] r_alu_out;
  logic [31:0] r_mdr;
  logic [31:0] r_wb_data;
  logic [31:0] r_cycles;
  logic [31:0] r_retired;
  logic        r_halted;
  logic [31:0] r_regs [0:31];
  logic [31:0] r_imem [0:(2**IMEM_AW)-1];
  logic [31:0] r_dmem [0:(2**DMEM_AW)-1];

  // Instruction fields, always taken from the latched IR
  logic [5:0]         w_op;
  logic [4:0]         w_rs;
  logic [4:0]         w_rt;
  logic [4:0]         w_rd;
  logic [5:0]         w_funct;
  logic               w_r_valid;
  logic               w_is_addi;
  logic               w_is_lw;
  logic               w_is_sw;
  logic               w_is_beq;
  logic               w_is_j;
  logic               w_is_halt;
  logic [31:0]        w_alu;
  logic [IMEM_AW-1:0] w_fetch_idx;
  logic [DMEM_AW-1:0] w_dmem_idx;
  logic [4:0]         w_wb_dest;
  logic [31:0]        w_wb_val;
  logic [31:0]        w_beq_target;
  logic [31:0]        w_j_target;
  state_t             w_boundary;
  logic [31:0]        w_result;

  assign w_op      = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_funct   = r_ir[5:0];

  assign w_is_addi = (w_op == OP_ADDI);
  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_j    = (w_op == OP_J);
  assign w_is_halt = (w_op == OP_HALT);

  // Fetch index wraps naturally because only the low word-address bits are used
  assign w_fetch_idx  = r_pc[IMEM_AW+1:2];
  // Data address aliases: bits above the memory depth and the byte offset are dropped
  assign w_dmem_idx   = r_alu_out[DMEM_AW+1:2];

  // R-type writes rd; addi and lw write rt
  assign w_wb_dest    = w_r_valid ? w_rd : w_rt;
  assign w_wb_val     = w_is_lw ? r_mdr : r_alu_out;

  // PC has already been incremented by FETCH when these are used in EXEC
  assign w_beq_target = r_pc + {r_imm[29:0], 2'b00};
  assign w_j_target   = {r_pc[31:28], r_ir[25:0], 2'b00};

  // Where to go after the last state of an instruction; RUN only matters here
  assign w_boundary   = RUN ? S_FETCH : S_IDLE;

  // Recognise the supported R-type functions; anything else is a NOP
  always_comb begin
    w_r_valid = 1'b0;
    if (w_op == OP_RTYPE) begin
      case (w_funct)
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_r_valid = 1'b1;
        default:                               w_r_valid = 1'b0;
      endcase
    end
  end

  // ALU: R-type uses A/B, everything else computes A + sign-extended immediate
  always_comb begin
    w_alu = r_a + r_imm;
    if (w_r_valid) begin
      case (w_funct)
        FN_ADD:  w_alu = r_a + r_b;
        FN_SUB:  w_alu = r_a - r_b;
        FN_AND:  w_alu = r_a & r_b;
        FN_OR:   w_alu = r_a | r_b;
        FN_SLT:  w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
        default: w_alu = r_a + r_b;
      endcase
    end
  end

  // Main control FSM with datapath registers, register file and counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_pc      <= 32'd0;
      r_ir      <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_imm     <= 32'd0;
      r_alu_out <= 32'd0;
      r_mdr     <= 32'd0;
      r_wb_data <= 32'd0;
      r_cycles  <= 32'd0;
      r_retired <= 32'd0;
      r_halted  <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (RUN) begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_ir    <= r_imem[w_fetch_idx];
          r_pc    <= r_pc + 32'd4;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a     <= r_regs[w_rs];
          r_b     <= r_regs[w_rt];
          r_imm   <= {{16{r_ir[15]}}, r_ir[15:0]};
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_r_valid || w_is_addi) begin
            r_alu_out <= w_alu;
            r_state   <= S_WB;
          end else if (w_is_lw || w_is_sw) begin
            r_alu_out <= w_alu;
            r_state   <= S_MEM;
          end else begin
            // beq, j, halt and unknown encodings all finish here
            if (w_is_beq && (r_a == r_b)) begin
              r_pc <= w_beq_target;
            end
            if (w_is_j) begin
              r_pc <= w_j_target;
            end
            r_retired <= r_retired + 32'd1;
            if (w_is_halt) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= w_boundary;
            end
          end
        end
        S_MEM: begin
          if (w_is_lw) begin
            r_mdr   <= r_dmem[w_dmem_idx];
            r_state <= S_WB;
          end else begin
            // sw: the data memory write happens in its own block this cycle
            r_retired <= r_retired + 32'd1;
            r_state   <= w_boundary;
          end
        end
        S_WB: begin
          if (w_wb_dest != 5'd0) begin
            r_regs[w_wb_dest] <= w_wb_val;
          end
          r_wb_data <= w_wb_val;
          r_retired <= r_retired + 32'd1;
          r_state   <= w_boundary;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if ((r_state != S_IDLE) && (r_state != S_HALT)) begin
        r_cycles <= r_cycles + 32'd1;
      end
    end
  end

  // Instruction memory load port, only open while the core is parked
  always_ff @(posedge CLK) begin
    if (!RST && WE && ((r_state == S_IDLE) || (r_state == S_HALT))) begin
      r_imem[W_Addr] <= W_Ins;
    end
  end

  // Data memory store; a reset in the same cycle suppresses it
  always_ff @(posedge CLK) begin
    if (!RST && (r_state == S_MEM) && w_is_sw) begin
      r_dmem[w_dmem_idx] <= r_b;
    end
  end

  // Debug view mux over registered state
  always_comb begin
    w_result = 32'd0;
    if (SLCT[4]) begin
      w_result = r_regs[{1'b0, SLCT[3:0]}];
    end else begin
      case (SLCT[3:0])
        4'd0:    w_result = r_pc;
        4'd1:    w_result = r_ir;
        4'd2:    w_result = r_a;
        4'd3:    w_result = r_b;
        4'd4:    w_result = r_alu_out;
        4'd5:    w_result = r_mdr;
        4'd6:    w_result = r_wb_data;
        4'd7:    w_result = r_cycles;
        4'd8:    w_result = r_retired;
        default: w_result = 32'd0;
      endcase
    end
  end

  assign PC     = r_pc;
  assign Result = w_result;
  assign STATE  = r_state;
  assign HALTED = r_halted;

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Bench for multi_cycle_mips: directed programs plus random straight-line
// programs, checked against an instruction-level model of the ISA.
module tb_multi_cycle_mips;

  localparam int IDEPTH = 256;
  localparam int DDEPTH = 256;

  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;

  logic        CLK;
  logic        RST;
  logic        WE;
  logic [7:0]  W_Addr;
  logic [31:0] W_Ins;
  logic        RUN;
  logic [4:0]  SLCT;
  logic [31:0] PC;
  logic [31:0] Result;
  logic [2:0]  STATE;
  logic        HALTED;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected per-cycle STATE trace of the current run
  logic [2:0] exp_q[$];

  // Reference model state
  logic [31:0] m_imem [0:IDEPTH-1];
  logic [31:0] m_dmem [0:DDEPTH-1];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;
  logic [31:0] m_cyc;
  logic [31:0] m_ret;
  logic [31:0] m_wb;

  multi_cycle_mips #(.IMEM_AW(8), .DMEM_AW(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .WE     (WE),
    .W_Addr (W_Addr),
    .W_Ins  (W_Ins),
    .RUN    (RUN),
    .SLCT   (SLCT),
    .PC     (PC),
    .Result (Result),
    .STATE  (STATE),
    .HALTED (HALTED)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {OP_J, 26'(target)};
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc  = 32'd0;
    m_cyc = 32'd0;
    m_ret = 32'd0;
    m_wb  = 32'd0;
  endtask

  task automatic model_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
    m_wb = v;
  endtask

  // Execute the program instruction by instruction until halt, producing the
  // final architectural state and the cycle-by-cycle STATE trace
  task automatic model_run();
    logic [31:0] ins, a, b, imm, addr;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    bit          done;
    bit          r_ok;
    done = 1'b0;
    exp_q.delete();
    for (int step = 0; step < 2000 && !done; step++) begin
      ins  = m_imem[m_pc[9:2]];
      m_pc = m_pc + 32'd4;
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
      a = m_regs[rs];
      b = m_regs[rt];
      imm = {{16{ins[15]}}, ins[15:0]};
      r_ok = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
      exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
      m_cyc = m_cyc + 32'd3;
      m_ret = m_ret + 32'd1;
      if (r_ok) begin
        case (fn)
          6'h20:   model_wr(rd, a + b);
          6'h22:   model_wr(rd, a - b);
          6'h24:   model_wr(rd, a & b);
          6'h25:   model_wr(rd, a | b);
          default: model_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        endcase
        exp_q.push_back(3'd5); m_cyc = m_cyc + 32'd1;
      end else if (op == OP_ADDI) begin
        model_wr(rt, a + imm);
        exp_q.push_back(3'd5); m_cyc = m_cyc + 32'd1;
      end else if (op == OP_LW) begin
        addr = a + imm;
        model_wr(rt, m_dmem[addr[9:2]]);
        exp_q.push_back(3'd4); exp_q.push_back(3'd5); m_cyc = m_cyc + 32'd2;
      end else if (op == OP_SW) begin
        addr = a + imm;
        m_dmem[addr[9:2]] = b;
        exp_q.push_back(3'd4); m_cyc = m_cyc + 32'd1;
      end else if (op == OP_BEQ) begin
        if (a == b) m_pc = m_pc + (imm << 2);
      end else if (op == OP_J) begin
        m_pc = {m_pc[31:28], ins[25:0], 2'b00};
      end else if (op == OP_HALT) begin
        done = 1'b1;
      end
    end
    if (done) exp_q.push_back(3'd6);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    model_reset();
  endtask

  task automatic load_ins(input int addr, input logic [31:0] ins);
    @(negedge CLK); WE = 1'b1; W_Addr = addr[7:0]; W_Ins = ins;
    @(negedge CLK); WE = 1'b0;
    m_imem[addr] = ins;
  endtask

  task automatic read_dbg(input logic [4:0] sel, output logic [31:0] val);
    @(negedge CLK); SLCT = sel; #1; val = Result;
  endtask

  task automatic check_final(input string tag);
    logic [31:0] v;
    chk({tag, "_pc_port"}, PC, m_pc);
    read_dbg(5'd0, v); chk({tag, "_pc_view"}, v, m_pc);
    read_dbg(5'd6, v); chk({tag, "_wb_data"}, v, m_wb);
    read_dbg(5'd7, v); chk({tag, "_cycles"}, v, m_cyc);
    read_dbg(5'd8, v); chk({tag, "_retired"}, v, m_ret);
    for (int r = 0; r < 16; r++) begin
      read_dbg(5'(16 + r), v);
      chk($sformatf("%s_reg%0d", tag, r), v, m_regs[r]);
    end
    chk({tag, "_halted"}, {31'd0, HALTED}, 32'd1);
    chk({tag, "_state_end"}, {29'd0, STATE}, 32'd6);
  endtask

  // Run the loaded program from IDLE, checking STATE every cycle; optionally
  // try to rewrite imem[1] during the first EXEC cycle (must be ignored)
  task automatic run_prog(input string tag, input bit poke_exec);
    bit poked;
    poked = 1'b0;
    model_run();
    @(negedge CLK); RUN = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      WE = 1'b0;
      chk({tag, "_trace"}, {29'd0, STATE}, {29'd0, exp_q.pop_front()});
      if (poke_exec && !poked && STATE == 3'd3) begin
        poked  = 1'b1;
        WE     = 1'b1;
        W_Addr = 8'd1;
        W_Ins  = enc_i(OP_ADDI, 0, 2, 16'd99);
      end
    end
    WE = 1'b0;
    // HALT holds even with RUN still high
    repeat (3) @(negedge CLK);
    RUN = 1'b0;
    check_final(tag);
  endtask

  // Random program: 8 initialising stores, 20 random instructions, halt
  task automatic gen_and_run(input int round);
    logic [5:0]  fn_tab [5];
    logic [15:0] bases [3];
    logic [31:0] ins;
    int          kind, off, maxoff, k;
    logic [15:0] imm;
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bases  = '{16'h0000, 16'h0400, 16'hFC00};
    do_reset();
    for (int w = 0; w < 8; w++) load_ins(w, enc_i(OP_SW, 0, 0, 16'(w * 4)));
    for (int i = 8; i < 28; i++) begin
      kind = $urandom_range(0, 7);
      k    = $urandom_range(0, 7);
      imm  = bases[$urandom_range(0, 2)] + 16'(k * 4 + $urandom_range(0, 3));
      maxoff = (28 - (i + 1) < 2) ? 28 - (i + 1) : 2;
      off  = $urandom_range(0, maxoff);
      case (kind)
        1:  ins = enc_i(OP_ADDI, $urandom_range(0, 15), $urandom_range(0, 15), 16'($urandom()));
        2:  ins = enc_i(OP_SW, 0, $urandom_range(0, 15), imm);
        3:  ins = enc_i(OP_LW, 0, $urandom_range(0, 15), imm);
        4:  ins = enc_i(OP_BEQ, $urandom_range(0, 3), $urandom_range(0, 3), 16'(off));
        5:  ins = enc_j(i + 1 + off);
        6:  ins = ($urandom_range(0, 1) == 1) ? {6'h3E, 26'($urandom())}
                                              : enc_r($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, 15), 6'h21);
        default: ins = enc_r($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                             fn_tab[$urandom_range(0, 4)]);
      endcase
      load_ins(i, ins);
    end
    load_ins(28, {OP_HALT, 26'd0});
    run_prog($sformatf("rand%0d", round), 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] v;
    RST = 1'b1; WE = 1'b0; RUN = 1'b0; SLCT = 5'd0; W_Addr = 8'd0; W_Ins = 32'd0;
    for (int i = 0; i < DDEPTH; i++) m_dmem[i] = 32'd0;
    for (int i = 0; i < IDEPTH; i++) m_imem[i] = 32'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();

    // Reset state
    chk("rst_state", {29'd0, STATE}, 32'd0);
    chk("rst_pc", PC, 32'd0);
    chk("rst_halted", {31'd0, HALTED}, 32'd0);
    for (int s = 0; s < 16; s++) begin
      read_dbg(5'(s), v); chk($sformatf("rst_view%0d", s), v, 32'd0);
    end
    read_dbg(5'd31, v); chk("rst_reg15", v, 32'd0);

    // addi/addi/add/halt
    load_ins(0, enc_i(OP_ADDI, 0, 1, 16'd5));
    load_ins(1, enc_i(OP_ADDI, 0, 2, 16'd7));
    load_ins(2, enc_r(1, 2, 3, 6'h20));
    load_ins(3, {OP_HALT, 26'd0});
    run_prog("basic", 1'b0);
    read_dbg(5'd19, v); chk("basic_r3_12", v, 32'd12);
    read_dbg(5'd7, v);  chk("basic_cyc15", v, 32'd15);
    read_dbg(5'd8, v);  chk("basic_ret4", v, 32'd4);

    // sw then lw, loaded while HALTED
    load_ins(0, enc_i(OP_ADDI, 0, 3, 16'h0055));
    load_ins(1, enc_i(OP_SW, 0, 3, 16'd8));
    load_ins(2, enc_i(OP_LW, 0, 4, 16'd8));
    load_ins(3, {OP_HALT, 26'd0});
    do_reset();
    run_prog("swlw", 1'b0);
    read_dbg(5'd20, v); chk("swlw_r4", v, 32'h55);
    read_dbg(5'd7, v);  chk("swlw_cyc16", v, 32'd16);

    // $0 stays zero; signed slt
    load_ins(0, enc_i(OP_ADDI, 0, 0, 16'd9));
    load_ins(1, enc_i(OP_ADDI, 0, 6, 16'hFFFF));
    load_ins(2, enc_i(OP_ADDI, 0, 7, 16'd1));
    load_ins(3, enc_r(6, 7, 5, 6'h2A));
    load_ins(4, {OP_HALT, 26'd0});
    do_reset();
    run_prog("slt", 1'b0);
    read_dbg(5'd16, v); chk("slt_r0", v, 32'd0);
    read_dbg(5'd21, v); chk("slt_r5", v, 32'd1);

    // WE during EXEC is ignored
    load_ins(0, enc_i(OP_ADDI, 0, 1, 16'd1));
    load_ins(1, enc_i(OP_ADDI, 0, 2, 16'd2));
    load_ins(2, {OP_HALT, 26'd0});
    do_reset();
    run_prog("we_exec", 1'b1);
    read_dbg(5'd18, v); chk("we_exec_r2", v, 32'd2);

    // Reset during MEM of sw leaves the data word alone
    load_ins(0, enc_i(OP_ADDI, 0, 3, 16'h0011));
    load_ins(1, enc_i(OP_SW, 0, 3, 16'd16));
    load_ins(2, {OP_HALT, 26'd0});
    do_reset();
    run_prog("sw_pre", 1'b0);
    load_ins(0, enc_i(OP_ADDI, 0, 3, 16'h0022));
    do_reset();
    @(negedge CLK); RUN = 1'b1;
    for (int c = 0; c < 20 && STATE != 3'd4; c++) @(negedge CLK);
    chk("rstmem_reached_mem", {29'd0, STATE}, 32'd4);
    RST = 1'b1;
    @(negedge CLK);
    chk("rstmem_state", {29'd0, STATE}, 32'd0);
    chk("rstmem_pc", PC, 32'd0);
    chk("rstmem_halted", {31'd0, HALTED}, 32'd0);
    RST = 1'b0; RUN = 1'b0;
    model_reset();
    load_ins(0, enc_i(OP_LW, 0, 4, 16'd16));
    load_ins(1, {OP_HALT, 26'd0});
    run_prog("rstmem", 1'b0);
    read_dbg(5'd20, v); chk("rstmem_word", v, 32'h11);

    // beq-to-self loop, RUN dropped after 10 cycles
    load_ins(0, enc_i(OP_BEQ, 0, 0, 16'hFFFF));
    do_reset();
    @(negedge CLK); RUN = 1'b1;
    repeat (10) @(posedge CLK);
    @(negedge CLK); RUN = 1'b0;
    for (int c = 0; c < 10 && STATE != 3'd0; c++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    chk("loop_state", {29'd0, STATE}, 32'd0);
    chk("loop_pc", PC, 32'd0);
    read_dbg(5'd8, v); chk("loop_ret", v, 32'd4);
    read_dbg(5'd7, v); chk("loop_cyc", v, 32'd12);

    // PC wrap past the top of instruction memory
    do_reset();
    load_ins(0, enc_i(OP_BEQ, 5, 0, 16'd1));
    load_ins(1, {OP_HALT, 26'd0});
    load_ins(2, enc_i(OP_ADDI, 0, 5, 16'd1));
    load_ins(3, enc_j(255));
    load_ins(255, enc_i(OP_ADDI, 0, 6, 16'd7));
    run_prog("wrap", 1'b0);
    chk("wrap_pc", PC, 32'h408);

    // Random programs
    for (int r = 0; r < 4; r++) gen_and_run(r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
